// File: rtl/sample_merge.sv
// sample_merge: assembles little-endian WIDTH-bit samples from a byte stream,
// flags each completed sample and drops partial samples after an inter-byte timeout.
module sample_merge #(
  parameter int WIDTH      = 16,
  parameter int TIMEOUT    = 255,
  parameter bit OFFSET_BIN = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic [7:0]       byte_i,
  input  logic             byte_valid_i,
  output logic [WIDTH-1:0] data_o,
  output logic             merge_finished_o,
  output logic             start_o,
  output logic             resync_o
);
  localparam int NB = WIDTH / 8;
  localparam int IW = NB > 1 ? $clog2(NB) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] MSB_FLIP = {OFFSET_BIN, {(WIDTH-1){1'b0}}};
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t           st_q, st_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sh_q, sh_d, data_q, data_d;
  logic             mf_q, mf_d, start_q, start_d, rs_q, rs_d;
  always_comb begin
    st_d    = st_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    start_d = start_q;
    mf_d    = 1'b0;
    rs_d    = 1'b0;
    if (!enable_i) begin
      st_d    = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
      start_d = 1'b0;
    end else if (byte_valid_i) begin
      // the final byte goes straight into the output word, so no bubble between samples
      sh_d[8*int'(idx_q) +: 8] = byte_i;
      cnt_d = '0;
      if (idx_q == IW'(NB - 1)) begin
        st_d    = IDLE;
        idx_d   = '0;
        data_d  = sh_d ^ MSB_FLIP;
        mf_d    = 1'b1;
        start_d = 1'b1;
      end else begin
        st_d  = COLLECT;
        idx_d = idx_q + IW'(1);
      end
    end else if (st_q == COLLECT) begin
      st_d  = cnt_q == CW'(TIMEOUT - 1) ? IDLE : COLLECT;
      idx_d = cnt_q == CW'(TIMEOUT - 1) ? '0 : idx_q;
      rs_d  = cnt_q == CW'(TIMEOUT - 1);
      cnt_d = cnt_q == CW'(TIMEOUT - 1) ? '0 : cnt_q + CW'(1);
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q    <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      mf_q    <= 1'b0;
      start_q <= 1'b0;
      rs_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      mf_q    <= mf_d;
      start_q <= start_d;
      rs_q    <= rs_d;
    end
  end
  assign data_o           = data_q;
  assign merge_finished_o = mf_q;
  assign start_o          = start_q;
  assign resync_o         = rs_q;
endmodule

// File: tb/tb_sample_merge.sv
// tb_sample_merge: directed checks of sample_merge, two's-complement and offset-binary instances side by side.
module tb_sample_merge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable_i = 1'b0;
  logic [7:0]  byte_i = 8'h00;
  logic        byte_valid_i = 1'b0;
  logic [15:0] data_tc, data_ob;
  logic        mf_tc, mf_ob, st_tc, st_ob, rs_tc, rs_ob;
  int          errors = 0;
  int          checks = 0;
  always #5 clk = ~clk;
  sample_merge #(.WIDTH(16), .TIMEOUT(4), .OFFSET_BIN(1'b0)) u_tc (
    .clk(clk), .rst(rst), .enable_i(enable_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .data_o(data_tc), .merge_finished_o(mf_tc), .start_o(st_tc), .resync_o(rs_tc));
  sample_merge #(.WIDTH(16), .TIMEOUT(4), .OFFSET_BIN(1'b1)) u_ob (
    .clk(clk), .rst(rst), .enable_i(enable_i), .byte_i(byte_i), .byte_valid_i(byte_valid_i),
    .data_o(data_ob), .merge_finished_o(mf_ob), .start_o(st_ob), .resync_o(rs_ob));
  task automatic send(input logic [7:0] b);
    byte_i = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
  endtask
  task automatic idle();
    byte_valid_i = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (data_tc !== 16'h0000) begin errors++; $display("FAIL reset_data: got %h expected 0000", data_tc); end
    checks++; if (mf_tc !== 1'b0) begin errors++; $display("FAIL reset_mf: got %b expected 0", mf_tc); end
    checks++; if (st_tc !== 1'b0 || st_ob !== 1'b0) begin errors++; $display("FAIL reset_start: got %b/%b expected 0/0", st_tc, st_ob); end
    checks++; if (rs_tc !== 1'b0) begin errors++; $display("FAIL reset_resync: got %b expected 0", rs_tc); end
    rst = 1'b1;
    enable_i = 1'b1;
    idle();
  endtask
  task automatic test_basic();
    send(8'h34);
    checks++; if (mf_tc !== 1'b0) begin errors++; $display("FAIL basic_mf_early: got %b expected 0", mf_tc); end
    send(8'h12);
    checks++; if (data_tc !== 16'h1234) begin errors++; $display("FAIL basic_data: got %h expected 1234", data_tc); end
    checks++; if (mf_tc !== 1'b1) begin errors++; $display("FAIL basic_mf: got %b expected 1", mf_tc); end
    checks++; if (st_tc !== 1'b1) begin errors++; $display("FAIL basic_start: got %b expected 1", st_tc); end
    idle();
    checks++; if (mf_tc !== 1'b0) begin errors++; $display("FAIL basic_mf_pulse: got %b expected 0", mf_tc); end
    checks++; if (st_tc !== 1'b1 || data_tc !== 16'h1234) begin errors++; $display("FAIL basic_hold: got start=%b data=%h expected 1/1234", st_tc, data_tc); end
  endtask
  task automatic test_back_to_back();
    logic [7:0]  bytes [6] = '{8'h01, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h80};
    logic [15:0] words [3] = '{16'h0001, 16'hFFFF, 16'h8000};
    for (int i = 0; i < 6; i++) begin
      send(bytes[i]);
      checks++; if (mf_tc !== logic'(i % 2)) begin errors++; $display("FAIL b2b_mf%0d: got %b expected %b", i, mf_tc, logic'(i % 2)); end
      if (i % 2 == 1) begin
        checks++; if (data_tc !== words[i/2]) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", i, data_tc, words[i/2]); end
      end
    end
    idle();
  endtask
  task automatic test_offset_bin();
    send(8'h00);
    send(8'h80);
    checks++; if (data_ob !== 16'h0000 || mf_ob !== 1'b1) begin errors++; $display("FAIL ob_first: got %h mf=%b expected 0000 mf=1", data_ob, mf_ob); end
    checks++; if (data_tc !== 16'h8000) begin errors++; $display("FAIL ob_tc_ref: got %h expected 8000", data_tc); end
    send(8'h00);
    send(8'h00);
    checks++; if (data_ob !== 16'h8000) begin errors++; $display("FAIL ob_second: got %h expected 8000", data_ob); end
    idle();
  endtask
  task automatic test_timeout();
    send(8'hAA);
    for (int i = 0; i < 3; i++) begin
      idle();
      checks++; if (rs_tc !== 1'b0) begin errors++; $display("FAIL to_early%0d: got %b expected 0", i, rs_tc); end
    end
    idle();
    checks++; if (rs_tc !== 1'b1 || rs_ob !== 1'b1) begin errors++; $display("FAIL to_pulse: got %b/%b expected 1/1", rs_tc, rs_ob); end
    checks++; if (mf_tc !== 1'b0 || st_tc !== 1'b1) begin errors++; $display("FAIL to_side: got mf=%b start=%b expected 0/1", mf_tc, st_tc); end
    idle();
    checks++; if (rs_tc !== 1'b0) begin errors++; $display("FAIL to_once: got %b expected 0", rs_tc); end
    repeat (6) idle();
    checks++; if (rs_tc !== 1'b0) begin errors++; $display("FAIL to_idle_quiet: got %b expected 0", rs_tc); end
    send(8'h78);
    send(8'h56);
    checks++; if (data_tc !== 16'h5678) begin errors++; $display("FAIL to_realign: got %h expected 5678", data_tc); end
    idle();
  endtask
  task automatic test_byte_wins();
    send(8'hAA);
    repeat (3) idle();
    send(8'hBB);
    checks++; if (rs_tc !== 1'b0) begin errors++; $display("FAIL win_resync: got %b expected 0", rs_tc); end
    checks++; if (data_tc !== 16'hBBAA || mf_tc !== 1'b1) begin errors++; $display("FAIL win_data: got %h mf=%b expected BBAA mf=1", data_tc, mf_tc); end
    idle();
  endtask
  task automatic test_reset_mid();
    send(8'h11);
    rst = 1'b0;
    #1;
    checks++; if (st_tc !== 1'b0 || data_tc !== 16'h0000) begin errors++; $display("FAIL rmid_async: got start=%b data=%h expected 0/0000", st_tc, data_tc); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'h22);
    checks++; if (mf_tc !== 1'b0 || st_tc !== 1'b0) begin errors++; $display("FAIL rmid_partial: got mf=%b start=%b expected 0/0", mf_tc, st_tc); end
    send(8'h33);
    checks++; if (data_tc !== 16'h3322 || st_tc !== 1'b1) begin errors++; $display("FAIL rmid_data: got %h start=%b expected 3322/1", data_tc, st_tc); end
    idle();
  endtask
  task automatic test_enable_drop();
    send(8'h44);
    enable_i = 1'b0;
    idle();
    checks++; if (st_tc !== 1'b0 || data_tc !== 16'h3322) begin errors++; $display("FAIL en_drop: got start=%b data=%h expected 0/3322", st_tc, data_tc); end
    send(8'h77);
    checks++; if (mf_tc !== 1'b0 || rs_tc !== 1'b0) begin errors++; $display("FAIL en_ignore: got mf=%b rs=%b expected 0/0", mf_tc, rs_tc); end
    enable_i = 1'b1;
    send(8'h55);
    checks++; if (mf_tc !== 1'b0 || st_tc !== 1'b0) begin errors++; $display("FAIL en_restart: got mf=%b start=%b expected 0/0", mf_tc, st_tc); end
    send(8'h66);
    checks++; if (data_tc !== 16'h6655 || st_tc !== 1'b1) begin errors++; $display("FAIL en_data: got %h start=%b expected 6655/1", data_tc, st_tc); end
    idle();
  endtask
  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_offset_bin();
    test_timeout();
    test_byte_wins();
    test_reset_mid();
    test_enable_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sample_merge.md
Name: sample_merge

Overview:
- Producer-side front end for the averaging/DC-removal stage of the FM demodulator.
- Takes the raw byte stream from the input interface and assembles little-endian WIDTH-bit signed samples.
- For each complete sample, presents the sample on data_o and pulses merge_finished_o for one clock.
- Drives start_o, which gates the downstream running-sum update, and discards partial samples after an inter-byte timeout so byte alignment recovers.

Parameters:
- WIDTH, 16: output sample width; must be a multiple of 8, with NB = WIDTH/8 bytes per sample.
- TIMEOUT, 255: idle clocks allowed between bytes of one sample before the partial sample is discarded; minimum 1.
- OFFSET_BIN, 0: 1 = input is offset binary, so the sample MSB is inverted on output; 0 = input is two's complement.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- enable_i  input  1  stream enable; low = ignore bytes, discard partial sample
- byte_i  input  8  input byte
- byte_valid_i  input  1  byte_i valid this cycle; one byte per valid cycle, no backpressure
- data_o  output  WIDTH  last assembled sample, signed; held until the next sample completes
- merge_finished_o  output  1  one-cycle pulse: data_o updated this cycle
- start_o  output  1  high from the first completed sample until enable_i drops or reset
- resync_o  output  1  one-cycle pulse: partial sample discarded by timeout

Behaviour:
- Reset (rst=0, asynchronous):
  - data_o=0, merge_finished_o=0, start_o=0, resync_o=0.
  - Byte index = 0, timeout counter = 0, shift register = 0, state IDLE.
- States:
  - IDLE: index 0, no partial sample held.
  - COLLECT: 1..NB-1 bytes held.
- Byte acceptance: a byte is accepted when enable_i=1 and byte_valid_i=1.
  - Accepted byte k (k = 0..NB-1, LSB first) is written to bits [8k+7:8k] of the shift register.
  - Index increments; the timeout counter clears.
- IDLE -> COLLECT on an accepted byte when NB>1.
- Completion: accepting byte NB-1 completes the sample.
  - On the next rising edge: data_o <= assembled word (MSB inverted if OFFSET_BIN=1), merge_finished_o <= 1, index <= 0, state <= IDLE, start_o <= 1.
  - Latency: last byte valid at edge n -> data_o/merge_finished_o valid after edge n+1. merge_finished_o is high for exactly one cycle unless another sample completes on the next cycle.
- Back-to-back: bytes on every cycle sustain one sample per NB cycles with no bubble. Byte 0 of the next sample is accepted in the same cycle merge_finished_o is high.
- data_o changes only on completion; it is never partially updated.
- Timeout: in COLLECT, each cycle with no accepted byte increments the counter (saturating).
  - When the counter reaches TIMEOUT: index <= 0, state <= IDLE, resync_o pulses one cycle.
  - data_o, start_o and merge_finished_o are unaffected.
  - If a byte arrives in the same cycle the counter would reach TIMEOUT, the byte wins: it is accepted and there is no resync.
- Timeout counter is held at 0 in IDLE.
- enable_i=0: bytes ignored, index <= 0, state <= IDLE, counter <= 0, start_o <= 0, no resync pulse; data_o holds.
- Re-enabling starts from byte 0. start_o rises again only after the next completed sample.
- Reset asserted mid-sample: partial bytes are lost and outputs return to reset values immediately. After release, the first byte is treated as byte 0.
- Counter width is clog2(TIMEOUT+1); no other arithmetic.

Test Plan:
- Reset, enable_i=1, WIDTH=16, bytes 0x34, 0x12 on consecutive cycles -> one clock after 0x12: data_o=0x1234, merge_finished_o=1 for 1 cycle, start_o=1 and stays high.
- Continuous valid bytes 0x01,0x00,0xFF,0xFF,0x00,0x80 -> merge_finished_o pulses every 2nd cycle; data_o = 0x0001, then 0xFFFF (-1), then 0x8000 (-32768).
- OFFSET_BIN=1, bytes 0x00,0x80 then 0x00,0x00 -> data_o=0x0000, then 0x8000.
- TIMEOUT=4: byte 0xAA, then 4 idle cycles -> resync_o pulses once, no merge_finished_o. Then 0x78, 0x56 -> data_o=0x5678 (0xAA discarded).
- TIMEOUT=4: byte 0xAA, 3 idle cycles, then 0xBB in the cycle the counter would reach 4 -> no resync_o; data_o=0xBBAA.
- Mid-sample disturbances:
  - Byte 0x11, then rst low for 1 cycle, then 0x22, 0x33 -> data_o=0x3322, start_o low until that completion.
  - enable_i dropped mid-sample -> start_o=0, partial sample discarded.
